tpu_c_drain: RTL and testbench

- Reads result rows out of the C buffer after a TPU run and streams them to the host as 32-bit words over a valid/ready interface.
- It is the read side of the C buffer; the TPU control FSM is the write side. It runs after TPU busy falls and shares the C buffer address/data widths.
- Each C entry is 128 bits (four 32-bit lanes). Rows are written in tiles of 4, so the row count is padded up to a multiple of 4.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/tpu_c_drain_if.sv | 36 +++
 rtl/tpu_word_serializer.sv | 79 +++++++
 rtl/tpu_c_drain.sv | 108 ++++++++++
 tb/tb_tpu_c_drain.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared constants, drain state encoding and row padding helper for the TPU C-buffer drain.
package tpu_pkg;

    localparam int ADDR_BITS  = 16;
    localparam int DATAC_BITS = 128;
    localparam int WORD_BITS  = 32;
    localparam int LANES      = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LAT  = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } drain_state_e;

    // Rows are written in tiles of four; 9 bits so 253..255 round up to 256.
    function automatic logic [8:0] pad4(input logic [7:0] n);
        logic [8:0] sum;
        sum = {1'b0, n} + 9'd3;
        return sum & ~9'd3;
    endfunction

endpackage

// File: rtl/tpu_c_drain_if.sv
// C-buffer read port and host word stream seen from the drain block (master) and its peers (slave).
interface tpu_c_drain_if #(
    parameter int ADDR_W = tpu_pkg::ADDR_BITS,
    parameter int DATA_W = tpu_pkg::DATAC_BITS,
    parameter int WORD_W = tpu_pkg::WORD_BITS
);

    logic              C_rd_en;
    logic [ADDR_W-1:0] C_index;
    logic [DATA_W-1:0] C_data_out;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output C_rd_en,
        output C_index,
        input  C_data_out,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  C_rd_en,
        input  C_index,
        output C_data_out,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/tpu_word_serializer.sv
// Holds one C entry and streams it out a word at a time over valid/ready, lowest lane first.
module tpu_word_serializer #(
    parameter int DATA_W    = tpu_pkg::DATAC_BITS,
    parameter int WORD_W    = tpu_pkg::WORD_BITS,
    parameter int NUM_LANES = tpu_pkg::LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              last_row_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              lane3_accepted_o
);

    localparam int LANE_BITS = $clog2(NUM_LANES);
    localparam logic [LANE_BITS-1:0] LAST_LANE   = LANE_BITS'(NUM_LANES - 1);
    localparam logic [LANE_BITS-1:0] PENULT_LANE = LANE_BITS'(NUM_LANES - 2);

    logic [DATA_W-1:0]    hold_q, hold_d;
    logic [LANE_BITS-1:0] lane_q, lane_d;
    logic                 valid_q, valid_d;
    logic                 last_row_q, last_row_d;
    logic                 last_q, last_d;
    logic                 accept;

    assign accept           = valid_q & out_ready_i;
    assign lane3_accepted_o = accept && (lane_q == LAST_LANE);

    // The holding register shifts down one word per accepted beat so the current
    // lane always sits in the low word and out_data comes straight from a flop.
    always_comb begin
        hold_d     = hold_q;
        lane_d     = lane_q;
        valid_d    = valid_q;
        last_row_d = last_row_q;
        last_d     = last_q;
        if (load_i) begin
            hold_d     = data_i;
            lane_d     = '0;
            valid_d    = 1'b1;
            last_row_d = last_row_i;
            last_d     = last_row_i && (NUM_LANES == 1);
        end else if (accept) begin
            if (lane_q == LAST_LANE) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                hold_d = hold_q >> WORD_W;
                lane_d = lane_q + LANE_BITS'(1);
                last_d = last_row_q && (lane_q == PENULT_LANE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q     <= '0;
            lane_q     <= '0;
            valid_q    <= 1'b0;
            last_row_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            lane_q     <= lane_d;
            valid_q    <= valid_d;
            last_row_q <= last_row_d;
            last_q     <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = hold_q[WORD_W-1:0];
    assign out_last_o  = last_q;

endmodule

// File: rtl/tpu_c_drain.sv
// Read side of the C buffer: walks the padded result rows after a TPU run and
// streams each 128-bit entry to the host as four 32-bit words.
module tpu_c_drain
    import tpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       num_rows,
    output logic             busy,
    output logic             done,
    tpu_c_drain_if.master    bus
);

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_REQ  = 3'(REQ);
    localparam logic [2:0] ST_LAT  = 3'(LAT);
    localparam logic [2:0] ST_SEND = 3'(SEND);
    localparam logic [2:0] ST_DONE = 3'(DONE);

    logic [2:0]           state_q, state_d;
    logic [8:0]           row_q, row_d;
    logic [8:0]           rows_total_q, rows_total_d;
    logic                 busy_q, done_q, rd_en_q;
    logic [ADDR_BITS-1:0] index_q;
    logic [8:0]           row_inc;
    logic [8:0]           padded_rows;
    logic                 is_last_row;
    logic                 load;
    logic                 lane3_accepted;

    assign row_inc     = row_q + 9'd1;
    assign is_last_row = (row_inc == rows_total_q);
    assign padded_rows = pad4(num_rows);
    assign load        = (state_q == ST_LAT);

    // One read per row with no prefetch: the next REQ waits for the last lane to be taken.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        rows_total_d = rows_total_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_total_d = padded_rows;
                    row_d        = '0;
                    state_d      = (padded_rows == 9'd0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  state_d = ST_LAT;
            ST_LAT:  state_d = ST_SEND;
            ST_SEND: begin
                if (lane3_accepted) begin
                    row_d   = row_inc;
                    state_d = is_last_row ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            rows_total_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            index_q      <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            rows_total_q <= rows_total_d;
            busy_q       <= (state_d == ST_REQ) || (state_d == ST_LAT) || (state_d == ST_SEND);
            done_q       <= (state_d == ST_DONE);
            rd_en_q      <= (state_d == ST_REQ);
            if (state_d == ST_REQ) begin
                index_q <= ADDR_BITS'(row_d);
            end
        end
    end

    tpu_word_serializer #(
        .DATA_W    (DATAC_BITS),
        .WORD_W    (WORD_BITS),
        .NUM_LANES (LANES)
    ) u_serializer (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_i           (load),
        .last_row_i       (is_last_row),
        .data_i           (bus.C_data_out),
        .out_ready_i      (bus.out_ready),
        .out_valid_o      (bus.out_valid),
        .out_data_o       (bus.out_data),
        .out_last_o       (bus.out_last),
        .lane3_accepted_o (lane3_accepted)
    );

    assign bus.C_rd_en = rd_en_q;
    assign bus.C_index = index_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tpu_c_drain.sv
// Directed vector bench for tpu_c_drain: a C-buffer model with one-cycle read latency
// and a host model whose readiness follows per-vector patterns.
module tb_tpu_c_drain;
    import tpu_pkg::*;

    typedef struct {
        int rows;
        int readyMode;
        int restartAt;
        int restartRows;
        int expTotal;
        int expFirstBeat;
        int expDoneCycle;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] numRows = 8'd0;
    logic       busy;
    logic       done;

    int checkCount = 0;
    int failCount  = 0;

    logic [DATAC_BITS-1:0] cMem [256];
    vec_t vecs [10];
    int readyPattern [6] = '{1, 0, 0, 1, 0, 1};

    tpu_c_drain_if bus ();

    tpu_c_drain dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_rows (numRows),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.C_rd_en) bus.C_data_out <= cMem[bus.C_index[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] expWord(input int beat, input int rows);
        int r;
        int l;
        r = beat / 4;
        l = beat % 4;
        return (r < rows) ? 32'(r * 4 + l) : 32'd0;
    endfunction

    task automatic fillMem(input int rows);
        for (int r = 0; r < 256; r++) begin
            cMem[r] = (r < rows) ? {32'(r * 4 + 3), 32'(r * 4 + 2), 32'(r * 4 + 1), 32'(r * 4)} : '0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rd_en"}, 32'(bus.C_rd_en), 32'd0);
        checkOutput({tag, "_index"}, 32'(bus.C_index), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_data"}, bus.out_data, 32'd0);
        checkOutput({tag, "_last"}, 32'(bus.out_last), 32'd0);
    endtask

    // Runs one complete drain; cycle n below is the n-th cycle after the edge that sampled start.
    task automatic applyStimulus(input vec_t v);
        int cycle;
        int beats;
        int rdCount;
        int doneCycle;
        int firstBeat;
        logic prevStall;
        logic [31:0] prevData;
        logic prevLast;

        fillMem(v.rows);
        numRows = 8'(v.rows);
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycle = 1;
        beats = 0;
        rdCount = 0;
        doneCycle = -1;
        firstBeat = -1;
        prevStall = 1'b0;
        prevData = '0;
        prevLast = 1'b0;

        while (doneCycle < 0 && cycle < 3000) begin
            case (v.readyMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (readyPattern[cycle % 6] != 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cycle == v.restartAt) begin
                start = 1'b1;
                numRows = 8'(v.restartRows);
            end else begin
                start = 1'b0;
            end

            if (bus.C_rd_en) begin
                checkOutput("c_index", 32'(bus.C_index), 32'(rdCount));
                checkOutput("rd_while_valid", 32'(bus.out_valid), 32'd0);
                rdCount++;
            end
            if (prevStall) begin
                checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("stall_data", bus.out_data, prevData);
                checkOutput("stall_last", 32'(bus.out_last), 32'(prevLast));
            end
            if (bus.out_valid && firstBeat < 0) firstBeat = cycle;
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("beat_data", bus.out_data, expWord(beats, v.rows));
                checkOutput("beat_last", 32'(bus.out_last), 32'(beats == v.expTotal * 4 - 1));
                beats++;
            end
            if (done) begin
                doneCycle = cycle;
                checkOutput("done_busy", 32'(busy), 32'd0);
                checkOutput("done_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                checkOutput("busy", 32'(busy), 32'd1);
            end

            prevStall = bus.out_valid && !bus.out_ready;
            prevData = bus.out_data;
            prevLast = bus.out_last;
            tick();
            cycle++;
        end

        start = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("done_seen", 32'(doneCycle >= 0), 32'd1);
        checkOutput("beat_count", 32'(beats), 32'(v.expTotal * 4));
        checkOutput("rd_count", 32'(rdCount), 32'(v.expTotal));
        if (v.expFirstBeat >= 0) checkOutput("first_beat_cycle", 32'(firstBeat), 32'(v.expFirstBeat));
        if (v.expDoneCycle >= 0) checkOutput("done_cycle", 32'(doneCycle), 32'(v.expDoneCycle));
        checkOutput("done_pulse_width", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        vecs[0] = '{4,   0, -1, 0, 4,   3,  25};
        vecs[1] = '{5,   0, -1, 0, 8,   3,  49};
        vecs[2] = '{0,   0, -1, 0, 0,  -1,   1};
        vecs[3] = '{4,   1, -1, 0, 4,   3,  -1};
        vecs[4] = '{4,   0,  4, 9, 4,   3,  25};
        vecs[5] = '{6,   0, -1, 0, 8,   3,  49};
        vecs[6] = '{1,   0, -1, 0, 4,   3,  25};
        vecs[7] = '{253, 0, -1, 0, 256, 3, 1537};
        vecs[8] = '{255, 0, -1, 0, 256, 3, 1537};
        vecs[9] = '{7,   2, -1, 0, 8,   3,  -1};

        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            $display("[TB] vector %0d: num_rows=%0d ready_mode=%0d", i, vecs[i].rows, vecs[i].readyMode);
            applyStimulus(vecs[i]);
        end

        // Reset pulse while row 2 is being streamed, then a fresh drain from row 0.
        fillMem(4);
        numRows = 8'd4;
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        checkOutput("row2_send_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("row2_send_data", bus.out_data, 32'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkAllZero("midreset");
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("post_reset_done", 32'(done), 32'd0);
            checkOutput("post_reset_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        applyStimulus('{4, 0, -1, 0, 4, 3, 25});

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
